// File: rtl/retire_pkg.sv
// Shared record type for the lockstep retire pairer.
package retire_pkg;

   localparam int RETIRE_REC_W = 96;

   typedef struct packed {
      logic [31:0] insn;
      logic [31:0] new_pc;
      logic [31:0] rd_wdata;
   } retire_rec_t;

endpackage

// File: rtl/retire_fifo.sv
// Per-core retire buffer: first-word-fall-through FIFO, push gated by full.
module retire_fifo
   import retire_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        push_i,
   input  retire_rec_t data_i,
   input  logic        pop_i,
   output retire_rec_t data_o,
   output logic        full_o,
   output logic        empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   retire_rec_t   mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          push_ok, pop_ok;

   assign full_o  = (cnt_q == FULL_CNT);
   assign empty_o = (cnt_q == '0);
   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;
   assign data_o  = mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push_ok && !pop_ok)      cnt_d = cnt_q + 1'b1;
      else if (!push_ok && pop_ok) cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage carries no reset; only the pointers define validity.
   always_ff @(posedge clk_i) begin
      if (push_ok && !rst_i) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/retire_pairer.sv
// Pairs core-1/core-2 retirements for the contract checker.
// Optional field comparator enabled by defining RETIRE_PAIR_CHECK_EN.
module retire_pairer
   import retire_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             retire_1_i,
   input  logic [31:0]      insn_1_i,
   input  logic [31:0]      new_pc_1_i,
   input  logic [31:0]      rd_wdata_1_i,
   input  logic             retire_2_i,
   input  logic [31:0]      insn_2_i,
   input  logic [31:0]      new_pc_2_i,
   input  logic [31:0]      rd_wdata_2_i,
   output logic             stall_1_o,
   output logic             stall_2_o,
   output logic             pair_valid_o,
   input  logic             pair_ready_i,
   output logic [31:0]      pair_insn_1_o,
   output logic [31:0]      pair_insn_2_o,
   output logic [31:0]      pair_new_pc_1_o,
   output logic [31:0]      pair_new_pc_2_o,
   output logic [31:0]      pair_rd_wdata_1_o,
   output logic [31:0]      pair_rd_wdata_2_o,
   output logic [CNT_W-1:0] pair_count_o,
   output logic             overflow_o,
   output logic             mismatch_o
);

   retire_rec_t      in_1, in_2, head_1, head_2;
   logic             full_1, full_2, empty_1, empty_2;
   logic             pop;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             overflow_q, overflow_d;

   assign in_1 = '{insn: insn_1_i, new_pc: new_pc_1_i, rd_wdata: rd_wdata_1_i};
   assign in_2 = '{insn: insn_2_i, new_pc: new_pc_2_i, rd_wdata: rd_wdata_2_i};

   retire_fifo #(.DEPTH(DEPTH)) u_fifo_1 (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .push_i (retire_1_i),
      .data_i (in_1),
      .pop_i  (pop),
      .data_o (head_1),
      .full_o (full_1),
      .empty_o(empty_1)
   );

   retire_fifo #(.DEPTH(DEPTH)) u_fifo_2 (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .push_i (retire_2_i),
      .data_i (in_2),
      .pop_i  (pop),
      .data_o (head_2),
      .full_o (full_2),
      .empty_o(empty_2)
   );

   assign pair_valid_o      = !empty_1 && !empty_2;
   assign pop               = pair_valid_o && pair_ready_i;
   assign stall_1_o         = full_1;
   assign stall_2_o         = full_2;
   assign pair_insn_1_o     = head_1.insn;
   assign pair_insn_2_o     = head_2.insn;
   assign pair_new_pc_1_o   = head_1.new_pc;
   assign pair_new_pc_2_o   = head_2.new_pc;
   assign pair_rd_wdata_1_o = head_1.rd_wdata;
   assign pair_rd_wdata_2_o = head_2.rd_wdata;
   assign pair_count_o      = cnt_q;
   assign overflow_o        = overflow_q;

   assign cnt_d      = pop ? cnt_q + 1'b1 : cnt_q;
   assign overflow_d = overflow_q
                     | (retire_1_i & full_1)
                     | (retire_2_i & full_2);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q      <= '0;
         overflow_q <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         overflow_q <= overflow_d;
      end
   end

`ifdef RETIRE_PAIR_CHECK_EN
   logic mismatch_q;

   always_ff @(posedge clk_i) begin
      if (rst_i)                           mismatch_q <= 1'b0;
      else if (pop && (head_1 != head_2))  mismatch_q <= 1'b1;
   end

   assign mismatch_o = mismatch_q;
`else
   assign mismatch_o = 1'b0;
`endif

endmodule
